// File: rtl/tff_toggle_arbiter_if.sv
// Bundle of request, mask and TFF-bank status signals for tff_toggle_arbiter.
// Define TFF_ARB_PARITY_EN to add the registered q_parity status bit.
interface tff_toggle_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic                    en;
  logic                    clr;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   mask;
  logic [NREQ-1:0]         gnt;
  logic [WIDTH-1:0]        q;
  logic                    busy;
  logic [CNT_W-1:0]        toggle_cnt;
`ifdef TFF_ARB_PARITY_EN
  logic                    q_parity;

  modport master (output en, clr, req, mask,
                  input  gnt, q, busy, toggle_cnt, q_parity);
  modport slave  (input  en, clr, req, mask,
                  output gnt, q, busy, toggle_cnt, q_parity);
`else
  modport master (output en, clr, req, mask,
                  input  gnt, q, busy, toggle_cnt);
  modport slave  (input  en, clr, req, mask,
                  output gnt, q, busy, toggle_cnt);
`endif
endinterface

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one TFF bank; each grant XORs the winner's mask into q,
// then a GAP-cycle cool-down blocks grants. TFF_ARB_PARITY_EN adds q_parity.
module tff_toggle_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  tff_toggle_arbiter_if.slave  bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, COOL} state_t;

  state_t              state_reg;
  logic [PTR_W-1:0]    ptr_reg;
  logic [3:0]          gcnt_reg;
  logic [NREQ-1:0]     gnt_reg;
  logic [WIDTH-1:0]    q_reg;
  logic                busy_reg;
  logic [CNT_W-1:0]    cnt_reg;

  logic [WIDTH-1:0]    mask_arr [NREQ];
  logic [PTR_W-1:0]    win;
  logic                found;
  logic                fire;
  logic [PTR_W-1:0]    ptr_next;
  logic [WIDTH-1:0]    q_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign mask_arr[gi] = bus.mask[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First set request at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[(int'(ptr_reg) + k) % NREQ]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr_reg) + k) % NREQ);
      end
    end
  end

  assign fire     = (state_reg == IDLE) && bus.en && found;
  assign ptr_next = (win == PTR_W'(NREQ-1)) ? '0 : win + 1'b1;

  // Clear wins over a same-edge toggle; the grant itself still happens.
  always_comb begin
    q_next = q_reg;
    if (bus.clr)
      q_next = '0;
    else if (fire)
      q_next = q_reg ^ mask_arr[win];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      gcnt_reg  <= '0;
      gnt_reg   <= '0;
      q_reg     <= '0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      gnt_reg <= '0;
      q_reg   <= q_next;
      case (state_reg)
        IDLE: begin
          if (fire) begin
            gnt_reg   <= NREQ'(1) << win;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_reg + 1'b1;
            state_reg <= COOL;
            busy_reg  <= 1'b1;
            gcnt_reg  <= 4'(GAP - 1);
          end
        end
        COOL: begin
          if (gcnt_reg == 4'd0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gcnt_reg <= gcnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_reg;
  assign bus.q          = q_reg;
  assign bus.busy       = busy_reg;
  assign bus.toggle_cnt = cnt_reg;

`ifdef TFF_ARB_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_reg <= 1'b0;
    else
      parity_reg <= ^q_next;
  end

  assign bus.q_parity = parity_reg;
`endif

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Directed bench for tff_toggle_arbiter (NREQ=4, WIDTH=8, GAP=2, CNT_W=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_tff_toggle_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tff_toggle_arbiter_if #(.NREQ(4), .WIDTH(8), .CNT_W(8)) bus ();

  tff_toggle_arbiter #(.NREQ(4), .WIDTH(8), .GAP(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] egnt, input logic [7:0] eq,
                         input logic ebusy, input logic [7:0] ecnt);
    check({tag, ".gnt"},  32'(bus.gnt),        32'(egnt));
    check({tag, ".q"},    32'(bus.q),          32'(eq));
    check({tag, ".busy"}, 32'(bus.busy),       32'(ebusy));
    check({tag, ".cnt"},  32'(bus.toggle_cnt), 32'(ecnt));
`ifdef TFF_ARB_PARITY_EN
    check({tag, ".par"},  32'(bus.q_parity),   32'(^eq));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  logic [7:0] exp_q3 [5];

  initial begin
    checks = 0;
    errors = 0;
    exp_q3 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h0E};

    // 1: reset held while everyone requests
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.clr  = 1'b0;
    bus.req  = 4'hF;
    bus.mask = {8'h08, 8'h04, 8'h02, 8'h01};
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rst_hold", 4'h0, 8'h00, 1'b0, 8'd0);
    end
    bus.req = 4'h0;
    rst     = 1'b0;
    tick();

    // 2: single requester, twice
    bus.mask = {8'h00, 8'h00, 8'h00, 8'h01};
    bus.req  = 4'b0001;
    tick(); chk_out("s2_g1", 4'b0001, 8'h01, 1'b1, 8'd1);
    bus.req  = 4'b0000;
    tick(); chk_out("s2_c1", 4'b0000, 8'h01, 1'b1, 8'd1);
    tick(); chk_out("s2_i1", 4'b0000, 8'h01, 1'b0, 8'd1);
    bus.req  = 4'b0001;
    tick(); chk_out("s2_g2", 4'b0001, 8'h00, 1'b1, 8'd2);
    bus.req  = 4'b0000;
    tick(); tick();

    // 3: all requesting, round robin from ptr 0
    pulse_rst();
    chk_out("s3_rst", 4'h0, 8'h00, 1'b0, 8'd0);
    bus.mask = {8'h08, 8'h04, 8'h02, 8'h01};
    bus.req  = 4'hF;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk_out($sformatf("s3_g%0d", g), 4'(1 << (g % 4)), exp_q3[g], 1'b1, 8'(g + 1));
      if (g == 4) bus.req = 4'h0;
      tick(); chk_out($sformatf("s3_c%0d", g), 4'h0, exp_q3[g], 1'b1, 8'(g + 1));
      tick(); chk_out($sformatf("s3_i%0d", g), 4'h0, exp_q3[g], 1'b0, 8'(g + 1));
    end

    // 4: clear on the grant edge beats the toggle
    bus.req = 4'b0001;
    tick(); chk_out("s4_set", 4'b0001, 8'h0F, 1'b1, 8'd6);
    bus.req = 4'b0000;
    tick(); tick();
    bus.mask = {8'h08, 8'h04, 8'hF0, 8'h01};
    bus.req  = 4'b0010;
    bus.clr  = 1'b1;
    tick(); chk_out("s4_clr", 4'b0010, 8'h00, 1'b1, 8'd7);
    bus.clr  = 1'b0;
    bus.req  = 4'b0000;
    tick(); tick();

    // 5: reset during cool-down returns ptr to 0
    pulse_rst();
    bus.req = 4'b0001;
    tick(); chk_out("s5_g0", 4'b0001, 8'h01, 1'b1, 8'd1);
    bus.req = 4'b0000;
    tick(); tick();
    bus.req = 4'b0010;
    tick(); chk_out("s5_g1", 4'b0010, 8'hF1, 1'b1, 8'd2);
    bus.req = 4'b0000;
    tick();
    rst = 1'b1;
    #2;
    chk_out("s5_async", 4'h0, 8'h00, 1'b0, 8'd0);
    rst = 1'b0;
    bus.req = 4'b0110;
    tick(); chk_out("s5_after", 4'b0010, 8'hF0, 1'b1, 8'd1);
    bus.req = 4'b0000;
    tick(); tick();

    // 6: enable low holds requests without losing them
    bus.en  = 1'b0;
    bus.req = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("s6_hold%0d", i), 4'h0, 8'hF0, 1'b0, 8'd1);
    end
    bus.en = 1'b1;
    tick(); chk_out("s6_go", 4'b0100, 8'hF4, 1'b1, 8'd2);
    bus.req = 4'b0000;
    tick(); tick();

    // 7: zero masks and grant counter wrap
    pulse_rst();
    bus.mask = '0;
    bus.req  = 4'hF;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 254) chk_out("s7_max",  4'(1 << (i % 4)), 8'h00, 1'b1, 8'd255);
      if (i == 255) chk_out("s7_wrap", 4'(1 << (i % 4)), 8'h00, 1'b1, 8'd0);
      tick(); tick();
    end
    bus.req = 4'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
